// File: rtl/pwm_duty_gen.sv
// PWM generator counting synchronized upstream ticks, with an IDLE/RUN/STOP lifecycle.
// Optional macro PWM_DUTY_GEN_SHADOW_EN adds period/duty shadow registers reloaded at wrap.
module pwm_duty_gen #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_tick_clk,
  input  logic             i_div_bypass,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_update,
  output logic             o_pwm,
  output logic             o_period_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ct_q, ct_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic             pwm_q, pwm_d, done_q, done_d, busy_q, busy_d;
  logic             tick, wrap;
  logic [WIDTH-1:0] period_act, duty_act, duty_nxt;

`ifdef PWM_DUTY_GEN_SHADOW_EN
  logic [WIDTH-1:0] period_q, period_d, duty_q, duty_d;
  logic             pend_q, pend_d;
  assign period_act = period_q;
  assign duty_act   = duty_q;
`else
  logic unused_update;
  assign unused_update = i_update;
  assign period_act    = i_period;
  assign duty_act      = i_duty;
`endif

  always_comb begin
    s1_d    = i_tick_clk;
    s2_d    = s1_q;
    s3_d    = s2_q;
    tick    = i_div_bypass | (s2_q & ~s3_q);
    state_d = state_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    wrap    = 1'b0;
`ifdef PWM_DUTY_GEN_SHADOW_EN
    period_d = period_q;
    duty_d   = duty_q;
    pend_d   = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = RUN;
          ct_d    = '0;
`ifdef PWM_DUTY_GEN_SHADOW_EN
          period_d = i_period;
          duty_d   = i_duty;
          pend_d   = 1'b0;
`endif
        end
      end
      RUN, STOP: begin
        wrap = tick && (ct_q >= period_act);
        if (tick) ct_d = wrap ? '0 : ct_q + 1'b1;
        done_d = wrap;
`ifdef PWM_DUTY_GEN_SHADOW_EN
        // A strobe landing on the wrap itself reloads immediately rather than waiting a period.
        if (wrap && (pend_q || i_update)) begin
          period_d = i_period;
          duty_d   = i_duty;
          pend_d   = 1'b0;
        end else if (i_update) begin
          pend_d = 1'b1;
        end
`endif
        if (state_q == RUN) begin
          if (!i_en) state_d = STOP;
        end else if (i_en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PWM_DUTY_GEN_SHADOW_EN
    duty_nxt = duty_d;
`else
    duty_nxt = duty_act;
`endif
    // Outputs are registered from next-state values so they line up with state_q/ct_q.
    pwm_d  = (state_d != IDLE) && (ct_d < duty_nxt);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (i_rst) begin
      state_q <= IDLE;
      ct_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pwm_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PWM_DUTY_GEN_SHADOW_EN
      period_q <= '0;
      duty_q   <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pwm_q   <= pwm_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef PWM_DUTY_GEN_SHADOW_EN
      period_q <= period_d;
      duty_q   <= duty_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign o_pwm         = pwm_q;
  assign o_period_done = done_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen: directed vector table, corner sequences and a random run
// against a cycle-level reference model; follows PWM_DUTY_GEN_SHADOW_EN if defined.
module tb_pwm_duty_gen;

  logic        clk = 1'b0;
  logic        rst, en, tc, byp, upd;
  logic [15:0] per, duty;
  logic        pwm, done, busy;

  logic        r4, en4;
  logic [3:0]  per4, duty4;
  logic        pwm4, done4, busy4;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain counters and flags.
  bit          m_active, m_drain, m_pwm, m_done, m_pend;
  int unsigned m_cnt, m_pa, m_da;
  bit          h1, h2, h3;

  always #5 clk = ~clk;

  pwm_duty_gen #(.WIDTH(16)) dut (
    .clk_i(clk), .i_rst(rst), .i_en(en), .i_tick_clk(tc), .i_div_bypass(byp),
    .i_period(per), .i_duty(duty), .i_update(upd),
    .o_pwm(pwm), .o_period_done(done), .o_busy(busy)
  );

  pwm_duty_gen #(.WIDTH(4)) dut4 (
    .clk_i(clk), .i_rst(r4), .i_en(en4), .i_tick_clk(1'b0), .i_div_bypass(1'b1),
    .i_period(per4), .i_duty(duty4), .i_update(1'b0),
    .o_pwm(pwm4), .o_period_done(done4), .o_busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the model; tick is derived from the history of sampled tick-clock values.
  task automatic model_edge();
    bit tick, wrap, p;
    int unsigned pp, dd;
    if (rst) begin
      m_active = 0; m_drain = 0; m_cnt = 0; m_pend = 0; m_pa = 0; m_da = 0;
      m_done = 0; m_pwm = 0; h1 = 0; h2 = 0; h3 = 0;
      return;
    end
    tick = byp || (h2 && !h3);
    h3 = h2; h2 = h1; h1 = tc;
    m_done = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_drain = 0; m_cnt = 0; m_pa = per; m_da = duty; m_pend = 0;
      end
    end else begin
`ifdef PWM_DUTY_GEN_SHADOW_EN
      pp = m_pa;
`else
      pp = per;
`endif
      wrap = tick && (m_cnt >= pp);
      if (tick) m_cnt = wrap ? 0 : m_cnt + 1;
      m_done = wrap;
      p = m_pend || upd;
      if (wrap && p) begin m_pa = per; m_da = duty; m_pend = 0; end
      else m_pend = p;
      if (!m_drain) begin
        if (!en) m_drain = 1;
      end else if (en) m_drain = 0;
      else if (wrap) begin m_active = 0; m_drain = 0; end
    end
`ifdef PWM_DUTY_GEN_SHADOW_EN
    dd = m_da;
`else
    dd = duty;
`endif
    m_pwm = m_active && (m_cnt < dd);
  endtask

  task automatic step(input bit r, input bit e, input bit b, input bit t,
                      input int unsigned p, input int unsigned d, input bit u);
    @(negedge clk);
    rst = r; en = e; byp = b; tc = t; per = p[15:0]; duty = d[15:0]; upd = u;
    model_edge();
    @(posedge clk);
    #1;
    check("model_pwm", pwm, m_pwm);
    check("model_done", done, m_done);
    check("model_busy", busy, m_active);
  endtask

  typedef struct {
    bit          rst, en;
    int unsigned per, duty;
    bit          e_pwm, e_done, e_busy;
  } vec_t;

  initial begin
    vec_t vecs[13];
    int   hi, dn, lo;
    bit   r_en, r_tc, r_byp, r_rst, r_upd;
    int unsigned r_per, r_duty;

    rst = 1; en = 0; tc = 0; byp = 1; upd = 0; per = 0; duty = 0;
    r4 = 1; en4 = 0; per4 = 4'd15; duty4 = 4'd15;

    // Bypass, period 4, duty 2: 2 high / 3 low, then drop enable and drain.
    vecs[0]  = '{1, 0, 4, 2, 0, 0, 0};
    vecs[1]  = '{0, 1, 4, 2, 1, 0, 1};
    vecs[2]  = '{0, 1, 4, 2, 1, 0, 1};
    vecs[3]  = '{0, 1, 4, 2, 0, 0, 1};
    vecs[4]  = '{0, 1, 4, 2, 0, 0, 1};
    vecs[5]  = '{0, 1, 4, 2, 0, 0, 1};
    vecs[6]  = '{0, 1, 4, 2, 1, 1, 1};
    vecs[7]  = '{0, 1, 4, 2, 1, 0, 1};
    vecs[8]  = '{0, 1, 4, 2, 0, 0, 1};
    vecs[9]  = '{0, 0, 4, 2, 0, 0, 1};
    vecs[10] = '{0, 0, 4, 2, 0, 0, 1};
    vecs[11] = '{0, 0, 4, 2, 0, 1, 0};
    vecs[12] = '{0, 0, 4, 2, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].en, 1, 0, vecs[i].per, vecs[i].duty, 0);
      check("vec_pwm", pwm, vecs[i].e_pwm);
      check("vec_done", done, vecs[i].e_done);
      check("vec_busy", busy, vecs[i].e_busy);
    end

    // Divided tick: tick clock toggles every 3 cycles, period 1, duty 1.
    step(1, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 60; k++) step(0, 1, 0, ((k / 3) % 2) == 1, 1, 1, 0);
    hi = 0; dn = 0;
    for (int k = 60; k < 84; k++) begin
      step(0, 1, 0, ((k / 3) % 2) == 1, 1, 1, 0);
      hi += int'(pwm); dn += int'(done);
    end
    check("div_high_cycles", hi, 12);
    check("div_done_count", dn, 2);

    // Duty 0 is constant low; duty above period is constant high.
    step(1, 0, 1, 0, 3, 0, 0);
    for (int k = 0; k < 10; k++) begin step(0, 1, 1, 0, 3, 0, 0); check("duty0_low", pwm, 0); end
    step(1, 0, 1, 0, 3, 10, 0);
    for (int k = 0; k < 10; k++) begin step(0, 1, 1, 0, 3, 10, 0); check("duty_big_high", pwm, 1); end

    // Mid-period duty change 2 -> 4 with update strobe.
    step(1, 0, 1, 0, 9, 2, 0);
    step(0, 1, 1, 0, 9, 2, 0);
    step(0, 1, 1, 0, 9, 2, 0);
    step(0, 1, 1, 0, 9, 2, 0);
    step(0, 1, 1, 0, 9, 4, 1);
`ifdef PWM_DUTY_GEN_SHADOW_EN
    check("upd_old_duty_held", pwm, 0);
`else
    check("upd_new_duty_now", pwm, 1);
`endif
    hi = 0;
    for (int k = 0; k < 7; k++) step(0, 1, 1, 0, 9, 4, 0);
    for (int k = 0; k < 10; k++) begin step(0, 1, 1, 0, 9, 4, 0); hi += int'(pwm); end
    check("upd_next_period_high", hi, 4);

    // Enable dropped at ct = 3 with period 7: drain to wrap once, then idle.
    step(1, 0, 1, 0, 7, 3, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 7, 3, 0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin step(0, 0, 1, 0, 7, 3, 0); dn += int'(done); end
    check("stop_done_once", dn, 1);
    check("stop_busy_low", busy, 0);
    check("stop_pwm_low", pwm, 0);

    // Reset at ct = 5 aborts the period without a done pulse.
    step(1, 0, 1, 0, 7, 6, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 7, 6, 0);
    check("pre_rst_pwm", pwm, 1);
    step(1, 1, 1, 0, 7, 6, 0);
    check("rst_pwm", pwm, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step(0, 0, 1, 0, 7, 6, 0);
    check("post_rst_done", done, 0);

    // Random run against the model.
    r_en = 0; r_tc = 0; r_byp = 0; r_per = 3; r_duty = 2;
    step(1, 0, 0, 0, r_per, r_duty, 0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) r_en = ~r_en;
      if ($urandom_range(0, 2) == 0) r_tc = ~r_tc;
      if ($urandom_range(0, 99) == 0) r_byp = ~r_byp;
      if ($urandom_range(0, 29) == 0) begin
        r_per = $urandom_range(0, 6);
        r_duty = $urandom_range(0, 9);
      end
      r_upd = ($urandom_range(0, 9) == 0);
      r_rst = ($urandom_range(0, 199) == 0);
      step(r_rst, r_en, r_byp, r_tc, r_per, r_duty, r_upd);
    end

    // All-ones period on a 4-bit instance: counter wraps after reaching 15.
    @(negedge clk); r4 = 1;
    @(negedge clk); r4 = 0; en4 = 1;
    @(posedge clk); #1;
    check("w4_start_busy", busy4, 1);
    dn = 0; lo = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      dn += int'(done4); lo += int'(!pwm4);
    end
    check("w4_done_count", dn, 2);
    check("w4_low_count", lo, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_duty_gen.md
PWM_DUTY_GEN -- requirements
Module: pwm_duty_gen

Interface
REQ-001 SHALL have parameter: WIDTH, 16, bit width of period, duty and counter.
REQ-002 SHALL have port: clk_i  input  1  single system clock; all flops sample on rising edge.
REQ-003 SHALL have port: i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_en  input  1  channel enable.
REQ-005 SHALL have port: i_tick_clk  input  1  divided clock from the upstream even down-clocker, asynchronous to clk_i phase.
REQ-006 SHALL have port: i_div_bypass  input  1  high when the upstream divisor is zero, so i_tick_clk equals clk_i.
REQ-007 SHALL have port: i_period  input  WIDTH  period minus one, in ticks.
REQ-008 SHALL have port: i_duty  input  WIDTH  high-time, in ticks.
REQ-009 SHALL have port: i_update  input  1  one-cycle strobe requesting a period/duty reload.
REQ-010 SHALL have port: o_pwm  output  1  PWM waveform.
REQ-011 SHALL have port: o_period_done  output  1  one-cycle pulse at each period wrap.
REQ-012 SHALL have port: o_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL synchronize i_tick_clk through two flops (s1, s2), then register s2 into s3; tick = s2 & ~s3.
- Rising edge sampled into s1 at clock edge N gives tick high during cycle N+1.
- Tick is a single clk_i cycle wide.
REQ-014 SHALL force tick = 1 every cycle while i_div_bypass = 1, regardless of i_tick_clk.
REQ-015 SHALL implement FSM states IDLE, RUN and STOP, with i_rst taking priority over all transitions.
- IDLE -> RUN: when i_en = 1; ct <= 0.
- RUN -> STOP: when i_en = 0.
- STOP -> RUN: when i_en = 1 before the wrap.
- STOP -> IDLE: on the wrap.
REQ-016 SHALL hold the WIDTH-bit counter ct unchanged unless tick = 1 in RUN or STOP.
REQ-017 SHALL, on tick in RUN or STOP, perform a wrap when ct >= period_act; otherwise ct <= ct + 1.
- A wrap sets ct <= 0 and pulses o_period_done on the next cycle.
- ct never overflows. With period_act = all-ones, ct wraps to 0 after reaching all-ones.
REQ-018 SHALL drive o_pwm = (state != IDLE) && (ct < duty_act), computed only from registered values.
- duty_act = 0 gives constant low.
- duty_act > period_act gives constant high.
- period_act = 0 gives a wrap on every tick with ct held at 0.
REQ-019 SHALL drive o_busy = (state != IDLE).
REQ-020 SHALL, when a wrap coincides with i_en = 0 in RUN, pulse o_period_done and go directly to STOP; STOP then completes one further full period.

Reset
REQ-021 SHALL, while i_rst = 1, set the following and ignore i_en, tick and i_update:
- state = IDLE, ct = 0, s1 = s2 = s3 = 0, update-pending = 0, o_pwm = 0, o_period_done = 0, o_busy = 0;
- period_act and duty_act = 0 when shadowed.
REQ-022 SHALL, on i_rst asserted mid-period, abort the period with no o_period_done pulse; o_pwm is low in the cycle following the reset edge.

Configuration
REQ-023 SHALL support macro PWM_DUTY_GEN_SHADOW_EN.
- Defined: period_act and duty_act are shadow registers.
  - Both are loaded from i_period/i_duty on the IDLE -> RUN transition.
  - i_update sets update-pending; at the next wrap both are loaded and the flag is cleared.
  - i_update coincident with a wrap loads at that wrap.
  - i_update while IDLE is ignored.
- Undefined: period_act = i_period and duty_act = i_duty combinationally, i_update is ignored, and no shadow or pending flops exist.

Verification
REQ-024 SHALL pass: bypass = 1, period = 4, duty = 2, en = 1 -> o_pwm repeats 2 high, 3 low; o_period_done pulses every 5 cycles.
REQ-025 SHALL pass: bypass = 0, i_tick_clk toggling every 3 clk_i cycles (period 6), period = 1, duty = 1 -> one tick per 6 cycles; o_pwm high 6, low 6; first tick 2 cycles after the first sampled rising edge.
REQ-026 SHALL pass: bypass = 1, duty = 0, then duty = 10 with period = 3 -> o_pwm constant 0, then constant 1 while busy.
REQ-027 SHALL pass: with SHADOW_EN, mid-period duty change 2 -> 4 with i_update -> old duty held until wrap, new duty from the next period; without SHADOW_EN -> new duty takes effect the next cycle.
REQ-028 SHALL pass: period = 7, en dropped at ct = 3 -> state STOP, count continues to 7, o_period_done pulses once, o_busy falls, o_pwm = 0 thereafter.
REQ-029 SHALL pass: i_rst = 1 at ct = 5 -> next cycle ct = 0, o_pwm = 0, o_busy = 0, no o_period_done pulse.
